// File: rtl/sdp_ram_pkg.sv
// rtl/sdp_ram_pkg.sv - shared types and helpers for the byte-strobed SDP RAM
package sdp_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_e;

    function automatic logic lane_parity(input logic [63:0] lane);
        return ^lane;
    endfunction

    function automatic int num_lanes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/sdp_ram_rd_pipe.sv
// rtl/sdp_ram_rd_pipe.sv - read result pipeline, RD_LATENCY register stages, holds data when idle
module sdp_ram_rd_pipe #(
    parameter int RD_LATENCY = 1,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [RD_LATENCY-1:0] vld;
    logic [WIDTH-1:0]      dat [RD_LATENCY];

    // Each stage only loads on a valid beat so the output holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[RD_LATENCY-1];
    assign out_data  = dat[RD_LATENCY-1];

endmodule

// File: rtl/byte_strobe_sdp_ram_ctl.sv
// rtl/byte_strobe_sdp_ram_ctl.sv - byte-strobed SDP RAM with zero sweep and forwarding; SDP_RAM_PARITY_EN adds lane parity
module byte_strobe_sdp_ram_ctl
    import sdp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    localparam int NUM_LANES = num_lanes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    input  logic                  wr_en,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_LANES-1:0]  wr_strb,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
`ifdef SDP_RAM_PARITY_EN
    ,
    output logic [NUM_LANES-1:0]  rd_par_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("RD_LATENCY must be 1 or 2");
        end
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    ram_state_e            state, state_nxt;
    logic [ADDR_WIDTH-1:0] init_addr, init_addr_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_acc, rd_acc;
    logic [NUM_LANES-1:0]  fwd;
    logic [DATA_WIDTH-1:0] rd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_addr <= '0;
        end else begin
            state     <= state_nxt;
            init_addr <= init_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        init_addr_nxt = init_addr;
        if (state == INIT) begin
            init_addr_nxt = init_addr + 1'b1;
            if (&init_addr) begin
                state_nxt = RUN;
            end
        end
    end

    assign init_done = (state == RUN);
    assign wr_ready  = init_done;
    assign wr_acc    = wr_en && wr_ready;
    assign rd_acc    = rd_en && init_done;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (state == INIT) begin
                mem[init_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= '0;
            end else if (wr_acc && wr_strb[i]) begin
                mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Write-first forwarding, decided lane by lane.
    always_comb begin
        fwd     = '0;
        rd_word = mem[rd_addr];
        for (int i = 0; i < NUM_LANES; i++) begin
            fwd[i] = wr_acc && (wr_addr == rd_addr) && wr_strb[i];
            if (fwd[i]) begin
                rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

`ifdef SDP_RAM_PARITY_EN
    localparam int PIPE_W = DATA_WIDTH + NUM_LANES;

    logic [NUM_LANES-1:0] par_mem [DEPTH];
    logic [NUM_LANES-1:0] par_err;
    logic [PIPE_W-1:0]    pipe_in, pipe_out;

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            par_mem[init_addr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_strb[i]) begin
                    par_mem[wr_addr][i] <= lane_parity(64'(wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]));
                end
            end
        end
    end

    always_comb begin
        par_err = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            par_err[i] = !fwd[i] &&
                (lane_parity(64'(mem[rd_addr][i*BYTE_WIDTH +: BYTE_WIDTH])) != par_mem[rd_addr][i]);
        end
    end

    assign pipe_in    = {par_err, rd_word};
    assign rd_data    = pipe_out[DATA_WIDTH-1:0];
    assign rd_par_err = pipe_out[PIPE_W-1:DATA_WIDTH];
`else
    localparam int PIPE_W = DATA_WIDTH;

    logic [PIPE_W-1:0] pipe_in, pipe_out;

    assign pipe_in = rd_word;
    assign rd_data = pipe_out;
`endif

    sdp_ram_rd_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .WIDTH      (PIPE_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_acc),
        .in_data   (pipe_in),
        .out_valid (rd_valid),
        .out_data  (pipe_out)
    );

endmodule

// File: tb/tb_byte_strobe_sdp_ram_ctl.sv
// tb/tb_byte_strobe_sdp_ram_ctl.sv - scoreboard bench for byte_strobe_sdp_ram_ctl
module tb_byte_strobe_sdp_ram_ctl;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int BW    = 8;
    localparam int LAT   = 2;
    localparam int NL    = 4;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done, wr_ready, rd_valid;
    logic          wr_en = 1'b0, rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0, rd_data;
    logic [NL-1:0] wr_strb = '0;
`ifdef SDP_RAM_PARITY_EN
    logic [NL-1:0] rd_par_err;
`endif

    always #5 clk = ~clk;

    byte_strobe_sdp_ram_ctl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BYTE_WIDTH (BW),
        .RD_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_done  (init_done),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
`ifdef SDP_RAM_PARITY_EN
        ,
        .rd_par_err (rd_par_err)
`endif
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [NL-1:0] err;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] model   [DEPTH];
    logic [NL-1:0] corrupt [DEPTH];
    logic [DW-1:0] last_data = '0;
    int            cyc = 0;
    int            rel_cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit running();
        return (cyc - rel_cyc) >= DEPTH;
    endfunction

    // Reference: writes apply strobed lanes first, so a same-cycle read sees write-first data.
    task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NL-1:0] ws, input bit re, input logic [AW-1:0] ra);
        @(posedge clk);
        #1;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws;
        rd_en = re; rd_addr = ra;
        if (running()) begin
            if (we) begin
                for (int i = 0; i < NL; i++) begin
                    if (ws[i]) begin
                        model[wa][BW*i +: BW] = wd[BW*i +: BW];
                        corrupt[wa][i] = 1'b0;
                    end
                end
            end
            if (re) q.push_back('{cyc + LAT, model[ra], corrupt[ra]});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel_cyc = cyc;
        for (int a = 0; a < DEPTH; a++) begin
            model[a] = '0;
            corrupt[a] = '0;
        end
        // Requests during the sweep must be dropped without side effects.
        while (!running()) begin
            drive(1'b1, AW'($urandom_range(0, 15)), DW'($urandom), NL'($urandom), 1'b1,
                  AW'($urandom_range(0, 15)));
        end
        idle(1);
    endtask

    always @(negedge clk) begin
        bit due_now;
        exp_t e;
        if (!rst_n) begin
            check("reset_rd_valid", 64'(rd_valid), 64'(0));
            check("reset_rd_data", 64'(rd_data), 64'(0));
            check("reset_init_done", 64'(init_done), 64'(0));
            last_data = '0;
        end else begin
            due_now = (q.size() > 0) && (q[0].due == cyc);
            check("init_done", 64'(init_done), 64'(running()));
            check("wr_ready", 64'(wr_ready), 64'(running()));
            check("rd_valid", 64'(rd_valid), 64'(due_now));
            if (due_now) begin
                e = q.pop_front();
                if (rd_valid) begin
                    check("rd_data", 64'(rd_data), 64'(e.data));
`ifdef SDP_RAM_PARITY_EN
                    check("rd_par_err", 64'(rd_par_err), 64'(e.err));
`endif
                end
                last_data = e.data;
            end else begin
                check("rd_data_hold", 64'(rd_data), 64'(last_data));
            end
        end
    end

    initial begin
        logic [AW-1:0] a;
        repeat (3) @(posedge clk);
        release_reset();

        drive(1'b0, '0, '0, '0, 1'b1, 9'd0);
        drive(1'b0, '0, '0, '0, 1'b1, 9'd255);
        drive(1'b0, '0, '0, '0, 1'b1, 9'd511);
        drive(1'b0, '0, '0, '0, 1'b1, 9'd5);

        drive(1'b1, 9'd3, 32'hAABBCCDD, 4'b1111, 1'b0, '0);
        drive(1'b1, 9'd3, 32'h11223344, 4'b0101, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 9'd3);
        idle(3);

        drive(1'b1, 9'd7, 32'h01020304, 4'b1111, 1'b0, '0);
        drive(1'b1, 9'd7, 32'hF0F0F0F0, 4'b1100, 1'b1, 9'd7);
        drive(1'b1, 9'd8, 32'hFFFFFFFF, 4'b0000, 1'b1, 9'd8);
        idle(3);

        for (int i = 0; i < 4; i++) begin
            a = AW'(i);
            drive(1'b1, a, 32'hC0DE0000 + DW'(i * 17), 4'b1111, 1'b0, '0);
        end
        for (int i = 0; i < 4; i++) begin
            a = AW'(i);
            drive(1'b0, '0, '0, '0, 1'b1, a);
        end
        idle(4);

        drive(1'b0, '0, '0, '0, 1'b1, 9'd3);
        drive(1'b1, 9'd3, 32'h55555555, 4'b1111, 1'b0, '0);
        idle(3);

`ifdef SDP_RAM_PARITY_EN
        drive(1'b1, 9'd9, 32'h000000FF, 4'b1111, 1'b0, '0);
        idle(1);
        dut.par_mem[9][0] = ~dut.par_mem[9][0];
        corrupt[9][0] = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b1, 9'd9);
        drive(1'b1, 9'd9, 32'h000000FF, 4'b0001, 1'b1, 9'd9);
        drive(1'b0, '0, '0, '0, 1'b1, 9'd9);
        idle(3);
`endif

        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), NL'($urandom),
                  1'($urandom), AW'($urandom_range(0, 15)));
        end
        idle(3);

        drive(1'b1, 9'd3, 32'h12345678, 4'b1111, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 9'd3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        q.delete();
        repeat (3) @(posedge clk);
        release_reset();

        drive(1'b0, '0, '0, '0, 1'b1, 9'd3);
        drive(1'b0, '0, '0, '0, 1'b1, 9'd7);
        idle(LAT + 2);

        check("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
